// File: rtl/tlc_vehicle_detector_if.sv
// Bus between the traffic light controller side and the farm-road vehicle detector.
interface tlc_vehicle_detector_if;
  logic       det_raw;
  logic [2:0] light_highway;
  logic [2:0] light_farm;
  logic       C;
  logic [7:0] veh_count;
  logic       starve;
  logic       lamp_fault;

  // Controller / environment side: drives detector and lamp codes, reads status.
  modport master (
    output det_raw,
    output light_highway,
    output light_farm,
    input  C,
    input  veh_count,
    input  starve,
    input  lamp_fault
  );

  // Detector side: consumes detector and lamp codes, produces request and status.
  modport slave (
    input  det_raw,
    input  light_highway,
    input  light_farm,
    output C,
    output veh_count,
    output starve,
    output lamp_fault
  );
endinterface

// File: rtl/tlc_vehicle_detector.sv
// Farm-road vehicle detector: synchronizes and debounces the loop detector,
// counts waiting vehicles, and raises a registered request C to the light
// controller, with starvation and illegal-lamp status flags.
module tlc_vehicle_detector #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned MAX_WAIT   = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  tlc_vehicle_detector_if.slave   bus
);

  localparam int unsigned RUN_W  = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned WAIT_W = 16;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};
  localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(DEB_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SERVE = 2'd2
  } state_e;

  logic [1:0]        sync_q;
  logic              det_sync;
  logic              det_stable;
  logic              det_prev;
  logic [RUN_W-1:0]  run_cnt;
  logic [2:0]        lamp_prev;
  logic              armed;
  logic [CNT_W-1:0]  veh_cnt_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  state_e            state;
  state_e            state_nxt;
  logic              c_q;
  logic              starve_q;
  logic              fault_q;

  logic              arrival;
  logic              farm_green;
  logic              green_entry;
  logic              lamp_bad;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == LAMP_RED) || (v == LAMP_YELLOW) || (v == LAMP_GREEN);
  endfunction

  assign det_sync    = sync_q[1];
  assign arrival     = det_stable & ~det_prev;
  assign farm_green  = (bus.light_farm == LAMP_GREEN);
  // armed blocks a false green entry on the first cycle out of reset.
  assign green_entry = armed & farm_green & (lamp_prev != LAMP_GREEN);
  assign lamp_bad    = ~is_onehot3(bus.light_highway) | ~is_onehot3(bus.light_farm) |
                       ((bus.light_highway != LAMP_RED) & (bus.light_farm != LAMP_RED));

  // Two-flop synchronizer for the asynchronous detector input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], bus.det_raw};
    end
  end

  // Debounce: accept a new level after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      det_stable <= 1'b0;
      run_cnt    <= '0;
    end else if (det_sync == det_stable) begin
      run_cnt <= '0;
    end else if (run_cnt == RUN_LAST) begin
      det_stable <= det_sync;
      run_cnt    <= '0;
    end else begin
      run_cnt <= run_cnt + RUN_W'(1);
    end
  end

  // Edge history for arrival and farm-green entry detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      det_prev  <= 1'b0;
      lamp_prev <= '0;
      armed     <= 1'b0;
    end else begin
      det_prev  <= det_stable;
      lamp_prev <= bus.light_farm;
      armed     <= 1'b1;
    end
  end

  // Waiting-vehicle counter: cleared on green entry, which wins over an arrival.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      veh_cnt_q <= '0;
    end else if (green_entry) begin
      veh_cnt_q <= '0;
    end else if (arrival && !farm_green && (veh_cnt_q != CNT_MAX)) begin
      veh_cnt_q <= veh_cnt_q + CNT_W'(1);
    end
  end

  // Request FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request FSM next state and saturating wait-counter next value.
  always_comb begin
    state_nxt = state;
    wait_nxt  = '0;
    case (state)
      ST_IDLE: begin
        if ((veh_cnt_q != '0) && (bus.light_farm == LAMP_RED)) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);
        if (bus.light_farm == LAMP_GREEN) state_nxt = ST_SERVE;
      end
      ST_SERVE: begin
        if (bus.light_farm == LAMP_RED) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered request decode, wait counter and sticky starve flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_q      <= 1'b0;
      wait_cnt <= '0;
      starve_q <= 1'b0;
    end else begin
      c_q      <= (state_nxt == ST_REQ);
      wait_cnt <= wait_nxt;
      starve_q <= starve_q | (wait_nxt == WAIT_LIM);
    end
  end

  // Sticky illegal-lamp status flag; observational only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_q | lamp_bad;
    end
  end

  assign bus.C          = c_q;
  assign bus.veh_count  = veh_cnt_q;
  assign bus.starve     = starve_q;
  assign bus.lamp_fault = fault_q;

endmodule

// File: tb/tb_tlc_vehicle_detector.sv
// Directed self-checking bench for tlc_vehicle_detector (DEB_CYCLES=4, MAX_WAIT=20).
module tb_tlc_vehicle_detector;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  tlc_vehicle_detector_if bus ();

  tlc_vehicle_detector #(
    .DEB_CYCLES (4),
    .MAX_WAIT   (20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.det_raw     = 1'b0;
    bus.light_highway = 3'b001;
    bus.light_farm  = 3'b100;
    step(2);
    rst_n = 1'b1;
  endtask

  // One clean vehicle: 7 cycles high (count updates on the 7th edge), 7 low.
  task automatic arrive(input string tag, input int exp_cnt, input bit do_chk);
    bus.det_raw = 1'b1;
    step(7);
    if (do_chk) check(tag, int'(bus.veh_count), exp_cnt);
    bus.det_raw = 1'b0;
    step(7);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset state
    do_reset();
    check("rst_C", int'(bus.C), 0);
    check("rst_veh", int'(bus.veh_count), 0);
    check("rst_starve", int'(bus.starve), 0);
    check("rst_fault", int'(bus.lamp_fault), 0);

    // Single arrival latency: stable at +6, count at +7, C at +8
    bus.det_raw = 1'b1;
    step(6);
    check("lat_veh6", int'(bus.veh_count), 0);
    step(1);
    check("lat_veh7", int'(bus.veh_count), 1);
    check("lat_C7", int'(bus.C), 0);
    step(1);
    check("lat_C8", int'(bus.C), 1);
    bus.det_raw = 1'b0;
    bus.light_highway = 3'b100;
    bus.light_farm = 3'b001;
    step(1);
    check("serve_veh", int'(bus.veh_count), 0);
    check("serve_C", int'(bus.C), 0);
    bus.light_highway = 3'b001;
    bus.light_farm = 3'b100;
    step(10);
    check("idle_C", int'(bus.C), 0);
    check("idle_starve", int'(bus.starve), 0);

    // Bounce rejection: 3 high / 3 low pulses never qualify
    for (int i = 0; i < 5; i++) begin
      bus.det_raw = 1'b1;
      step(3);
      bus.det_raw = 1'b0;
      step(3);
    end
    step(8);
    check("bounce_veh", int'(bus.veh_count), 0);
    check("bounce_C", int'(bus.C), 0);

    // Three arrivals, then farm green clears and serves
    arrive("arr1", 1, 1'b1);
    arrive("arr2", 2, 1'b1);
    arrive("arr3", 3, 1'b1);
    check("arr3_C", int'(bus.C), 1);
    bus.light_highway = 3'b100;
    bus.light_farm = 3'b001;
    step(1);
    check("green_veh", int'(bus.veh_count), 0);
    check("green_C", int'(bus.C), 0);
    arrive("green_arr", 0, 1'b1);
    bus.light_highway = 3'b001;
    bus.light_farm = 3'b100;
    step(3);
    check("back_red_C", int'(bus.C), 0);
    check("back_red_veh", int'(bus.veh_count), 0);

    // Arrival coincident with green entry is not counted
    arrive("pre_coinc", 1, 1'b1);
    bus.det_raw = 1'b1;
    step(6);
    bus.light_highway = 3'b100;
    bus.light_farm = 3'b001;
    step(1);
    check("coinc_veh", int'(bus.veh_count), 0);
    check("coinc_C", int'(bus.C), 0);
    bus.det_raw = 1'b0;
    bus.light_highway = 3'b001;
    bus.light_farm = 3'b100;
    step(8);
    check("post_coinc_C", int'(bus.C), 0);

    // Starve timing and count saturation with farm held red
    do_reset();
    bus.det_raw = 1'b1;
    step(8);
    check("sat_C_on", int'(bus.C), 1);
    check("sat_veh1", int'(bus.veh_count), 1);
    step(19);
    check("starve_19", int'(bus.starve), 0);
    step(1);
    check("starve_20", int'(bus.starve), 1);
    bus.det_raw = 1'b0;
    step(7);
    for (int k = 2; k <= 300; k++) begin
      arrive("sat_cnt", (k < 255) ? k : 255, (k == 254) || (k == 255) || (k == 256) || (k == 300));
    end
    check("sat_C", int'(bus.C), 1);

    // Illegal farm code 011: sticky fault, state and count untouched
    check("fault_pre", int'(bus.lamp_fault), 0);
    bus.light_farm = 3'b011;
    step(1);
    check("fault_011", int'(bus.lamp_fault), 1);
    bus.light_farm = 3'b100;
    step(2);
    check("fault_sticky", int'(bus.lamp_fault), 1);
    check("fault_C", int'(bus.C), 1);
    check("fault_veh", int'(bus.veh_count), 255);

    // Both lamps green from idle
    do_reset();
    check("rst2_fault", int'(bus.lamp_fault), 0);
    check("rst2_starve", int'(bus.starve), 0);
    bus.light_highway = 3'b001;
    bus.light_farm = 3'b001;
    step(1);
    check("fault_both", int'(bus.lamp_fault), 1);
    bus.light_farm = 3'b100;
    step(2);
    check("fault_both_sticky", int'(bus.lamp_fault), 1);
    check("fault_both_C", int'(bus.C), 0);

    // One-cycle reset while requesting with five vehicles
    do_reset();
    for (int k = 1; k <= 5; k++) arrive("r5_cnt", k, 1'b1);
    check("r5_C", int'(bus.C), 1);
    check("r5_starve", int'(bus.starve), 1);
    bus.light_farm = 3'b011;
    step(1);
    bus.light_farm = 3'b100;
    step(1);
    check("r5_fault", int'(bus.lamp_fault), 1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("r5_rst_C", int'(bus.C), 0);
    check("r5_rst_veh", int'(bus.veh_count), 0);
    check("r5_rst_starve", int'(bus.starve), 0);
    check("r5_rst_fault", int'(bus.lamp_fault), 0);
    step(2);
    check("r5_after_C", int'(bus.C), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
